// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot occupancy counter.
// Holds the passage FSM states, the count width, the default capacity and a saturating count helper.
package parking_pkg;

   localparam int COUNT_W          = 3;
   localparam int DEFAULT_MAX_CARS = 7;

   typedef enum logic [2:0] {
      IDLE,
      IN_A,
      IN_AB,
      IN_B,
      OUT_B,
      OUT_AB,
      OUT_A,
      ERR
   } state_t;

   // Saturating up/down step: never wraps below zero or above the capacity.
   function automatic logic [COUNT_W-1:0] sat_step(
      input logic [COUNT_W-1:0] count,
      input logic               inc,
      input logic               dec,
      input logic [COUNT_W-1:0] max_count
   );
      logic [COUNT_W-1:0] result;
      result = count;
      if (inc && (count < max_count)) begin
         result = count + 1'b1;
      end else if (dec && (count != '0)) begin
         result = count - 1'b1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw sensor.
// The clean output follows the synchronised input only after it has differed for DEBOUNCE_CYCLES cycles in a row.
module sensor_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic clean
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] stable_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         clean      <= 1'b0;
         stable_cnt <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         // Any cycle where the synchronised value agrees with the output restarts the count.
         if (sync2 != clean) begin
            if (stable_cnt == LAST_CNT) begin
               clean      <= sync2;
               stable_cnt <= '0;
            end else begin
               stable_cnt <= stable_cnt + 1'b1;
            end
         end else begin
            stable_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/parking_counter.sv
// Parking-lot occupancy counter: two debounced sensors feed a passage FSM that
// drives a saturating car count and full flag shown on four LEDs.
module parking_counter
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_CARS        = DEFAULT_MAX_CARS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_A,
   input  logic       btn_B,
   output logic [3:0] leds
);

   localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_CARS);

   logic               a_clean;
   logic               b_clean;
   state_t             state;
   state_t             next_state;
   logic               entry_next;
   logic               exit_next;
   logic               entry_pulse;
   logic               exit_pulse;
   logic [COUNT_W-1:0] count;
   logic [COUNT_W-1:0] next_count;
   logic               full;

   sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb_a (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_A),
      .clean(a_clean)
   );

   sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb_b (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_B),
      .clean(b_clean)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         entry_pulse <= 1'b0;
         exit_pulse  <= 1'b0;
      end else begin
         state       <= next_state;
         entry_pulse <= entry_next;
         exit_pulse  <= exit_next;
      end
   end

   // Passage recogniser on the debounced pair {a,b}; OUT_ states mirror IN_ states with A and B swapped.
   always_comb begin
      next_state = state;
      entry_next = 1'b0;
      exit_next  = 1'b0;
      case (state)
         IDLE: begin
            case ({a_clean, b_clean})
               2'b10:   next_state = IN_A;
               2'b01:   next_state = OUT_B;
               2'b11:   next_state = ERR;
               default: next_state = IDLE;
            endcase
         end
         IN_A: begin
            case ({a_clean, b_clean})
               2'b10:   next_state = IN_A;
               2'b11:   next_state = IN_AB;
               2'b00:   next_state = IDLE;
               default: next_state = ERR;
            endcase
         end
         IN_AB: begin
            case ({a_clean, b_clean})
               2'b11:   next_state = IN_AB;
               2'b01:   next_state = IN_B;
               2'b10:   next_state = IN_A;
               default: next_state = ERR;
            endcase
         end
         IN_B: begin
            case ({a_clean, b_clean})
               2'b01:   next_state = IN_B;
               2'b11:   next_state = IN_AB;
               2'b00: begin
                  next_state = IDLE;
                  entry_next = 1'b1;
               end
               default: next_state = ERR;
            endcase
         end
         OUT_B: begin
            case ({a_clean, b_clean})
               2'b01:   next_state = OUT_B;
               2'b11:   next_state = OUT_AB;
               2'b00:   next_state = IDLE;
               default: next_state = ERR;
            endcase
         end
         OUT_AB: begin
            case ({a_clean, b_clean})
               2'b11:   next_state = OUT_AB;
               2'b10:   next_state = OUT_A;
               2'b01:   next_state = OUT_B;
               default: next_state = ERR;
            endcase
         end
         OUT_A: begin
            case ({a_clean, b_clean})
               2'b10:   next_state = OUT_A;
               2'b11:   next_state = OUT_AB;
               2'b00: begin
                  next_state = IDLE;
                  exit_next  = 1'b1;
               end
               default: next_state = ERR;
            endcase
         end
         ERR: begin
            if ({a_clean, b_clean} == 2'b00) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      next_count = sat_step(count, entry_pulse, exit_pulse, MAX_COUNT);
   end

   // Full flag is registered from the same next value so it never lags the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         full  <= 1'b0;
      end else begin
         count <= next_count;
         full  <= (next_count == MAX_COUNT);
      end
   end

   assign leds = {full, count};

endmodule

// File: tb/tb_parking_counter.sv
// Self-checking bench for parking_counter: directed passages plus random sensor walks,
// compared against a trace-based passage model.
module tb_parking_counter;

   localparam int D   = 4;
   localparam int MAX = 7;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       btn_A = 1'b0;
   logic       btn_B = 1'b0;
   logic [3:0] leds;

   int   vectors     = 0;
   int   miscompares = 0;
   bit   check_en    = 1'b0;
   logic [3:0] exp_q[$];

   // Model: a passage is the list of settled patterns between two 00 levels.
   int         m_count;
   logic [1:0] m_prev;
   logic [1:0] m_first;
   bit         m_bad;

   parking_counter #(
      .DEBOUNCE_CYCLES(D),
      .MAX_CARS       (MAX)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .btn_A(btn_A),
      .btn_B(btn_B),
      .leds (leds)
   );

   // clock
   always #5 clk = ~clk;

   function automatic logic [3:0] model_leds();
      logic [2:0] c;
      c = 3'(m_count);
      return {(m_count == MAX), c};
   endfunction

   task automatic model_reset();
      m_count = 0;
      m_prev  = 2'b00;
      m_first = 2'b00;
      m_bad   = 1'b0;
   endtask

   // A passage counts only if every step flips one sensor; direction comes from first and last patterns.
   task automatic model_step(input logic [1:0] ab);
      if (ab == m_prev) return;
      if (m_prev == 2'b00) begin
         m_first = ab;
         m_bad   = ($countones(ab) != 1);
      end else begin
         if ($countones(ab ^ m_prev) != 1) m_bad = 1'b1;
         if (ab == 2'b00 && !m_bad) begin
            if (m_first == 2'b10 && m_prev == 2'b01 && m_count < MAX) m_count++;
            if (m_first == 2'b01 && m_prev == 2'b10 && m_count > 0)   m_count--;
         end
      end
      m_prev = ab;
   endtask

   task automatic push_exp();
      exp_q.delete();
      exp_q.push_back(model_leds());
   endtask

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: leds=%b required=%b at %0t", name, act, req, $time);
      end
   endtask

   // scoreboard compare process
   always @(posedge clk) begin
      #1;
      if (check_en && exp_q.size() > 0) check("model", leds, exp_q[0]);
   end

   // glitch: 0 none, 1 pulse A, 2 pulse B (only on a sensor not changing in this step)
   task automatic apply(input logic a, input logic b, input int glitch);
      logic prev_a;
      logic prev_b;
      @(negedge clk);
      prev_a = btn_A;
      prev_b = btn_B;
      btn_A  = a;
      btn_B  = b;
      model_step({a, b});
      push_exp();
      repeat (3) @(negedge clk);
      if (glitch == 1 && prev_a == a) begin
         btn_A = ~a;
         @(negedge clk);
         btn_A = a;
      end else if (glitch == 2 && prev_b == b) begin
         btn_B = ~b;
         @(negedge clk);
         btn_B = b;
      end
      repeat (D + 10) @(negedge clk);
      check_en = 1'b1;
      repeat (4) @(negedge clk);
      check_en = 1'b0;
   endtask

   task automatic entry_seq(input int glitch);
      apply(1'b1, 1'b0, glitch);
      apply(1'b1, 1'b1, 0);
      apply(1'b0, 1'b1, glitch);
      apply(1'b0, 1'b0, 0);
   endtask

   task automatic exit_seq(input int glitch);
      apply(1'b0, 1'b1, glitch);
      apply(1'b1, 1'b1, 0);
      apply(1'b1, 1'b0, glitch);
      apply(1'b0, 1'b0, 0);
   endtask

   initial begin
      logic [1:0] cur;
      logic [1:0] nxt;
      logic [1:0] flip;
      int         g;
      logic [3:0] req;

      model_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("reset", leds, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      push_exp();

      entry_seq(0);
      check("entry1", leds, 4'b0001);
      exit_seq(0);
      check("exit1", leds, 4'b0000);
      exit_seq(0);
      check("exit_at_zero", leds, 4'b0000);
      apply(1'b1, 1'b0, 0);
      apply(1'b0, 1'b0, 0);
      check("partial_entry", leds, 4'b0000);

      for (int i = 1; i <= 7; i++) begin
         entry_seq((i == 3) ? 1 : ((i == 5) ? 2 : 0));
         req = (i == 7) ? 4'b1111 : 4'(i);
         check("fill", leds, req);
      end
      entry_seq(0);
      check("entry_when_full", leds, 4'b1111);

      apply(1'b1, 1'b0, 0);
      apply(1'b0, 1'b1, 0);
      apply(1'b1, 1'b0, 0);
      apply(1'b0, 1'b0, 0);
      check("invalid_seq", leds, 4'b1111);

      for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1);
      check("glitch_idle", leds, 4'b1111);

      exit_seq(1);
      check("exit_from_full", leds, 4'b0110);

      // reset while A is held mid-passage
      apply(1'b1, 1'b0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 check("reset_mid", leds, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      model_step({btn_A, btn_B});
      push_exp();
      apply(1'b1, 1'b0, 0);
      apply(1'b1, 1'b1, 0);
      apply(1'b0, 1'b1, 0);
      apply(1'b0, 1'b0, 0);
      check("entry_after_reset", leds, 4'b0001);

      // random walks, mostly single-sensor flips
      cur = 2'b00;
      for (int i = 0; i < 120; i++) begin
         flip = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
         if ($urandom_range(0, 3) != 0) nxt = cur ^ flip;
         else                           nxt = 2'($urandom_range(0, 3));
         g = $urandom_range(0, 5);
         apply(nxt[1], nxt[0], (g < 3) ? g : 0);
         cur = nxt;
      end
      apply(1'b0, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
